// File: rtl/square_seq_ctrl.sv
// square_seq_ctrl: duty-unit sequencer for one APU square channel.
// Holds the mode and 11-bit period registers, runs the frequency
// down-counter on ACLK1 enables, and steps the 3-bit duty counter.
//
// Interface contract: there is no valid/ready handshake anywhere in this
// block. WR0/WR2/WR3 are one-cycle write strobes and are always accepted.
// FLOAD/FCO are one-cycle, fire-and-forget output strobes.
module square_seq_ctrl (
  input  logic       CLK,
  input  logic       RES,
  input  logic       ACLK1,
  input  logic       WR0,
  input  logic       WR2,
  input  logic       WR3,
  input  logic [7:0] DB,
  output logic       FLOAD,
  output logic       FCO,
  output logic [2:0] STEP,
  output logic       MUTE,
  output logic       DUTY
);

  logic [1:0]  mode;
  logic [10:0] period;
  logic [10:0] period_next;
  logic [10:0] cnt;
  logic [2:0]  step;
  logic        fload_q;
  logic        fco_q;
  logic        duty_raw;

  // Period as it stands after any write on this edge. A reload that lands
  // on the same edge as a period write must pick up the new value.
  always_comb begin
    period_next = period;
    if (WR2) period_next[7:0]  = DB;
    if (WR3) period_next[10:8] = DB[2:0];
  end

  // Registers, timer, duty step and reload strobes.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      mode    <= 2'd0;
      period  <= 11'd0;
      cnt     <= 11'd0;
      step    <= 3'd0;
      fload_q <= 1'b0;
      fco_q   <= 1'b0;
    end else begin
      if (WR0) mode <= DB[7:6];
      period  <= period_next;
      fload_q <= 1'b0;
      fco_q   <= 1'b0;
      if (ACLK1) begin
        if (cnt == 11'd0) begin
          cnt     <= period_next;
          fload_q <= 1'b1;
          fco_q   <= 1'b1;
          step    <= step - 3'd1;
        end else begin
          cnt <= cnt - 11'd1;
        end
      end
      // The phase reset overrides a step decrement on the same edge.
      if (WR3) step <= 3'd0;
    end
  end

  // Duty table lookup, driven only from registered mode and step.
  always_comb begin
    duty_raw = 1'b0;
    case (mode)
      2'd0: duty_raw = (step == 3'd7);
      2'd1: duty_raw = (step >= 3'd6);
      2'd2: duty_raw = step[2];
      2'd3: duty_raw = (step <= 3'd5);
      default: duty_raw = 1'b0;
    endcase
  end

  assign MUTE  = (period[10:3] == 8'd0);
  assign DUTY  = duty_raw & ~MUTE;
  assign STEP  = step;
  assign FLOAD = fload_q;
  assign FCO   = fco_q;

endmodule

// File: tb/tb_square_seq_ctrl.sv
// tb_square_seq_ctrl: directed bench for square_seq_ctrl with
// hand-computed expected values.
module tb_square_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RES;
  logic       ACLK1;
  logic       WR0;
  logic       WR2;
  logic       WR3;
  logic [7:0] DB;
  logic       FLOAD;
  logic       FCO;
  logic [2:0] STEP;
  logic       MUTE;
  logic       DUTY;

  int n_checks = 0;
  int n_fail   = 0;

  // Samples captured right after an ACLK1 edge.
  logic       s_fload;
  logic       s_fco;
  logic [2:0] s_step;
  logic       s_duty;
  logic       s_mute;

  square_seq_ctrl dut (
    .CLK   (CLK),
    .RES   (RES),
    .ACLK1 (ACLK1),
    .WR0   (WR0),
    .WR2   (WR2),
    .WR3   (WR3),
    .DB    (DB),
    .FLOAD (FLOAD),
    .FCO   (FCO),
    .STEP  (STEP),
    .MUTE  (MUTE),
    .DUTY  (DUTY)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic w0, input logic w2, input logic w3, input logic [7:0] d);
    WR0 = w0; WR2 = w2; WR3 = w3; DB = d;
    tick();
    WR0 = 1'b0; WR2 = 1'b0; WR3 = 1'b0;
  endtask

  // One ACLK1 pulse followed by an idle cycle; the strobe must be gone again.
  task automatic pulse;
    ACLK1 = 1'b1;
    tick();
    s_fload = FLOAD; s_fco = FCO; s_step = STEP; s_duty = DUTY; s_mute = MUTE;
    ACLK1 = 1'b0;
    tick();
    check("strobe_width", {15'd0, FLOAD}, 16'd0);
  endtask

  // Pulse until a reload; n returns the number of pulses used.
  task automatic wait_reload(output int n);
    n = 0;
    do begin
      pulse();
      n++;
    end while (!s_fload && n < 20);
    if (!s_fload) check("reload_timeout", 16'd0, 16'd1);
  endtask

  logic [7:0] duty_tab [4];
  logic [1:0] sweep_mode [3];
  int         sweep_hi [3];

  initial begin
    int n;
    int hi;
    logic [2:0] es;
    duty_tab[0] = 8'b1000_0000;
    duty_tab[1] = 8'b1100_0000;
    duty_tab[2] = 8'b1111_0000;
    duty_tab[3] = 8'b0011_1111;
    sweep_mode[0] = 2'd0; sweep_mode[1] = 2'd1; sweep_mode[2] = 2'd3;
    sweep_hi[0] = 1; sweep_hi[1] = 2; sweep_hi[2] = 6;

    // Reset held with random bus activity
    RES = 1'b1; ACLK1 = 1'b0; WR0 = 1'b0; WR2 = 1'b0; WR3 = 1'b0; DB = 8'h00;
    for (int i = 0; i < 3; i++) begin
      WR0 = 1'($urandom_range(0, 1));
      WR2 = 1'($urandom_range(0, 1));
      WR3 = 1'($urandom_range(0, 1));
      DB  = 8'($urandom_range(0, 255));
      tick();
      check("rst_fload", {15'd0, FLOAD}, 16'd0);
      check("rst_fco",   {15'd0, FCO},   16'd0);
      check("rst_step",  {13'd0, STEP},  16'd0);
      check("rst_mute",  {15'd0, MUTE},  16'd1);
      check("rst_duty",  {15'd0, DUTY},  16'd0);
    end
    WR0 = 1'b0; WR2 = 1'b0; WR3 = 1'b0;
    RES = 1'b0;
    tick();
    pulse();
    check("first_fload", {15'd0, s_fload}, 16'd1);
    check("first_step",  {13'd0, s_step},  16'd7);
    check("first_duty",  {15'd0, s_duty},  16'd0);

    // 50% duty at period 8
    write_reg(1, 0, 0, 8'h80);
    write_reg(0, 1, 0, 8'h08);
    write_reg(0, 0, 1, 8'h00);
    check("p50_mute", {15'd0, MUTE}, 16'd0);
    check("p50_step", {13'd0, STEP}, 16'd0);
    for (int r = 0; r < 9; r++) begin
      es = 3'(7 - r);
      pulse();
      check("p50_fco",   {15'd0, s_fco},   16'd1);
      check("p50_fload", {15'd0, s_fload}, 16'd1);
      check("p50_rstep", {13'd0, s_step},  {13'd0, es});
      check("p50_duty",  {15'd0, s_duty},  {15'd0, (es >= 3'd4)});
      if (r < 8) begin
        for (int k = 0; k < 8; k++) begin
          pulse();
          check("p50_nofco", {15'd0, s_fco}, 16'd0);
        end
      end
    end

    // Mode sweep at period 8
    for (int mi = 0; mi < 3; mi++) begin
      write_reg(1, 0, 0, {sweep_mode[mi], 6'd0});
      write_reg(0, 0, 1, 8'h00);
      hi = 0;
      for (int r = 0; r < 8; r++) begin
        es = 3'(7 - r);
        wait_reload(n);
        check("sweep_step", {13'd0, s_step}, {13'd0, es});
        check("sweep_duty", {15'd0, s_duty}, {15'd0, duty_tab[sweep_mode[mi]][es]});
        hi += int'(s_duty);
      end
      check("sweep_hi", 16'(hi), 16'(sweep_hi[mi]));
    end

    // Phase reset mid-cycle, then WR3 coincident with a reload
    write_reg(1, 0, 0, 8'h80);
    n = 0;
    for (int t = 0; t < 10 && STEP != 3'd3; t++) wait_reload(n);
    check("ph_at3", {13'd0, STEP}, 16'd3);
    write_reg(0, 0, 1, 8'h00);
    check("ph_step0", {13'd0, STEP}, 16'd0);
    check("ph_mute",  {15'd0, MUTE}, 16'd0);
    for (int k = 0; k < 8; k++) begin
      pulse();
      check("ph_nofload", {15'd0, s_fload}, 16'd0);
    end
    ACLK1 = 1'b1; WR3 = 1'b1; DB = 8'h00;
    tick();
    check("ph_co_fload", {15'd0, FLOAD}, 16'd1);
    check("ph_co_step",  {13'd0, STEP},  16'd0);
    ACLK1 = 1'b0; WR3 = 1'b0;
    tick();

    // Mute boundary
    write_reg(0, 0, 1, 8'h00);
    write_reg(0, 1, 0, 8'h07);
    check("mute_on",   {15'd0, MUTE}, 16'd1);
    check("mute_duty", {15'd0, DUTY}, 16'd0);
    wait_reload(n);
    wait_reload(n);
    check("mute_interval", 16'(n), 16'd8);
    check("mute_rduty", {15'd0, s_duty}, 16'd0);
    check("mute_rmute", {15'd0, s_mute}, 16'd1);
    write_reg(0, 1, 0, 8'h08);
    check("mute_off", {15'd0, MUTE}, 16'd0);

    // Reset mid-operation at STEP 5 with writes in flight
    for (int t = 0; t < 10 && STEP != 3'd5; t++) wait_reload(n);
    check("mid_at5", {13'd0, STEP}, 16'd5);
    WR0 = 1'b1; WR2 = 1'b1; DB = 8'hC9;
    #2 RES = 1'b1;
    #1;
    check("mid_fload", {15'd0, FLOAD}, 16'd0);
    check("mid_fco",   {15'd0, FCO},   16'd0);
    check("mid_step",  {13'd0, STEP},  16'd0);
    check("mid_mute",  {15'd0, MUTE},  16'd1);
    check("mid_duty",  {15'd0, DUTY},  16'd0);
    tick();
    WR0 = 1'b0; WR2 = 1'b0;
    RES = 1'b0;
    tick();
    check("mid_period_lost", {15'd0, MUTE}, 16'd1);
    write_reg(0, 1, 0, 8'h08);
    wait_reload(n);
    check("mid_first_n",    16'(n), 16'd1);
    check("mid_step7",      {13'd0, s_step}, 16'd7);
    check("mid_duty7",      {15'd0, s_duty}, 16'd1);
    wait_reload(n);
    check("mid_interval",   16'(n), 16'd9);
    check("mid_mode_lost",  {15'd0, s_duty}, 16'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
